mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register and write-back select for the 5-stage MIPS core.
//  Latches MEM-stage results, extends/aligns load data, and picks the write-back value.
//  Drives the register file write port (A3_WB/WE_WB/WD_WB) one cycle after MEM.
//  Also keeps a retired-instruction counter and flags misaligned loads.
// PARAMETERS
//  CNT_W   32  width of retired-instruction counter InstRet
// PORTS
//  Clk        in   1   clock, all state on posedge
//  Reset_n    in   1   asynchronous, active-low reset
//  Stall      in   1   hold all stage state this cycle
//  Flush      in   1   insert bubble into WB this cycle
//  Valid_M    in   1   MEM stage holds a real instruction
//  RegWrite_M in   1   instruction writes a GPR
//  A3_M       in   5   destination register number
//  WbSel_M    in   2   0=ALU, 1=load data, 2=PC+8, 3=reserved (treated as ALU)
//  LoadType_M in   3   0=lw 1=lb 2=lbu 3=lh 4=lhu, 5-7 treated as lw
//  ALUOut_M   in   32  ALU result / effective address; [1:0] is byte offset
//  MemRD_M    in   32  raw aligned word read from data memory
//  PC8_M      in   32  PC+8 for jal/jalr link
//  A3_WB      out  5   GPR write address
//  WE_WB      out  1   GPR write enable
//  WD_WB      out  32  GPR write data
//  Valid_W    out  1   WB stage holds a real instruction
//  LoadErr_W  out  1   WB instruction is a misaligned load (write suppressed)
//  InstRet    out  CNT_W  count of instructions accepted into WB
// BEHAVIOUR
//  Reset (Reset_n=0, async): all outputs and internal registers 0, including InstRet.
//  Latency: MEM inputs at edge N appear on WB outputs right after edge N; pure 1-cycle register.
//  Priority at each posedge: Flush > Stall > capture.
//   Flush: Valid_W=0, WE_WB=0, A3_WB=0, WD_WB=0, LoadErr_W=0; InstRet unchanged.
//   Stall (no Flush): every register, including InstRet, holds its value.
//   Capture: register the values below, computed combinationally from the M inputs.
//  Load extract, off=ALUOut_M[1:0], big-endian lanes (off 0 = MemRD_M[31:24]):
//   lb/lbu: byte = MemRD_M[31-8*off -: 8]. lb sign-extends, lbu zero-extends.
//   lh/lhu: half = off[1] ? MemRD_M[15:0] : MemRD_M[31:16]. lh sign-extends, lhu zero-extends.
//   lw: MemRD_M unchanged.
//  Misaligned load: WbSel_M==1 and (lw with off!=0, or lh/lhu with off[0]==1).
//   Then LoadErr_W=1 and WE_WB=0. WD_WB still shows the extracted value.
//  WD_WB = WbSel 1 ? load value : WbSel 2 ? PC8_M : ALUOut_M.
//  WE_WB = Valid_M & RegWrite_M & (A3_M!=0) & ~misaligned. $0 is never written.
//  A3_WB = A3_M when Valid_M, else 0. Valid_W = Valid_M.
//  LoadErr_W = Valid_M & misaligned. A bubble (Valid_M=0) never raises WE_WB or LoadErr_W.
//  InstRet += 1 on each capture with Valid_M=1.
//   Wraps from all-ones to 0 with no flag. Flushed or stalled cycles do not count.
//  Reset_n asserted mid-operation clears everything at once, including a pending write.
//   WE_WB is low for the first edge after release unless a valid write is captured.
// TESTING
//  1. addu: ALUOut=0x12345678, A3=8, WbSel=0, RegWrite=1
//     -> next cycle A3_WB=8, WE_WB=1, WD_WB=0x12345678, InstRet=1.
//  2. MemRD=0x80FF7F01. lb off=0 -> WD=0xFFFFFF80. lbu off=1 -> 0x000000FF.
//     lh off=2 -> 0x00007F01. lhu off=0 -> 0x000080FF.
//  3. lw off=2 with A3=9 -> WE_WB=0, LoadErr_W=1, Valid_W=1.
//     lh off=1 -> same. Next aligned lw -> LoadErr_W=0.
//  4. jal: WbSel=2, PC8=0x00003008, A3=31 -> WD_WB=0x00003008, WE_WB=1.
//     A3=0 with RegWrite=1 -> WE_WB=0.
//  5. Stall 3 cycles -> outputs and InstRet frozen. Stall+Flush together -> bubble.
//     Flush alone -> Valid_W=0, WE_WB=0, InstRet unchanged.
//  6. Preload InstRet to all-ones via CNT_W=4 and 15 valid captures, then one more
//     -> InstRet=0. Pulse Reset_n low mid-stream -> all outputs 0 at once.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side results and pipeline control going in,
// register-file write port and WB status coming out.
interface mem_wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             Stall;
  logic             Flush;
  logic             Valid_M;
  logic             RegWrite_M;
  logic [4:0]       A3_M;
  logic [1:0]       WbSel_M;
  logic [2:0]       LoadType_M;
  logic [31:0]      ALUOut_M;
  logic [31:0]      MemRD_M;
  logic [31:0]      PC8_M;
  logic [4:0]       A3_WB;
  logic             WE_WB;
  logic [31:0]      WD_WB;
  logic             Valid_W;
  logic             LoadErr_W;
  logic [CNT_W-1:0] InstRet;

  modport master (
    output Stall, Flush, Valid_M, RegWrite_M, A3_M, WbSel_M, LoadType_M,
           ALUOut_M, MemRD_M, PC8_M,
    input  A3_WB, WE_WB, WD_WB, Valid_W, LoadErr_W, InstRet
  );

  modport slave (
    input  Stall, Flush, Valid_M, RegWrite_M, A3_M, WbSel_M, LoadType_M,
           ALUOut_M, MemRD_M, PC8_M,
    output A3_WB, WE_WB, WD_WB, Valid_W, LoadErr_W, InstRet
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns/extends load data, selects the
// write-back value, drives the GPR write port one cycle after MEM, counts
// retired instructions and flags misaligned loads.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input logic           Clk,
  input logic           Reset_n,
  mem_wb_stage_if.slave bus
);

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  // Big-endian lane pick plus sign/zero extension; codes 5-7 behave as lw.
  function automatic logic [31:0] load_extract(input logic [2:0]  lt,
                                               input logic [1:0]  off,
                                               input logic [31:0] rd);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] ext_s;
    logic [31:0]        res;
    case (off)
      2'd0:    byte_s = rd[31:24];
      2'd1:    byte_s = rd[23:16];
      2'd2:    byte_s = rd[15:8];
      default: byte_s = rd[7:0];
    endcase
    half_s = off[1] ? rd[15:0] : rd[31:16];
    ext_s  = '0;
    case (lt)
      LT_LB:   begin ext_s = byte_s; res = ext_s; end
      LT_LBU:  res = {24'd0, byte_s};
      LT_LH:   begin ext_s = half_s; res = ext_s; end
      LT_LHU:  res = {16'd0, half_s};
      default: res = rd;
    endcase
    return res;
  endfunction

  // Only loads can be misaligned; lb/lbu accept any offset.
  function automatic logic is_misaligned(input logic [1:0] wb_sel,
                                         input logic [2:0] lt,
                                         input logic [1:0] off);
    logic bad;
    case (lt)
      LT_LB, LT_LBU: bad = 1'b0;
      LT_LH, LT_LHU: bad = off[0];
      default:       bad = (off != 2'd0);
    endcase
    return (wb_sel == 2'd1) && bad;
  endfunction

  logic [1:0]       off_p0;
  logic             mis_p0;
  logic [31:0]      load_p0;
  logic [31:0]      wd_p0;
  logic             we_p0;
  logic [4:0]       a3_p0;
  logic             err_p0;

  logic [4:0]       a3_p1;
  logic             we_p1;
  logic [31:0]      wd_p1;
  logic             vld_p1;
  logic             err_p1;
  logic [CNT_W-1:0] inst_ret;

  // MEM side: next WB values computed from the current M inputs.
  always_comb begin
    off_p0  = bus.ALUOut_M[1:0];
    mis_p0  = is_misaligned(bus.WbSel_M, bus.LoadType_M, off_p0);
    load_p0 = load_extract(bus.LoadType_M, off_p0, bus.MemRD_M);
    case (bus.WbSel_M)
      2'd1:    wd_p0 = load_p0;
      2'd2:    wd_p0 = bus.PC8_M;
      default: wd_p0 = bus.ALUOut_M;
    endcase
    we_p0  = bus.Valid_M & bus.RegWrite_M & (bus.A3_M != 5'd0) & ~mis_p0;
    a3_p0  = bus.Valid_M ? bus.A3_M : 5'd0;
    err_p0 = bus.Valid_M & mis_p0;
  end

  // WB register: flush inserts a bubble, stall holds, otherwise capture.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a3_p1    <= '0;
      we_p1    <= 1'b0;
      wd_p1    <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      inst_ret <= '0;
    end else if (bus.Flush) begin
      a3_p1  <= '0;
      we_p1  <= 1'b0;
      wd_p1  <= '0;
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else if (!bus.Stall) begin
      a3_p1  <= a3_p0;
      we_p1  <= we_p0;
      wd_p1  <= wd_p0;
      vld_p1 <= bus.Valid_M;
      err_p1 <= err_p0;
      if (bus.Valid_M)
        inst_ret <= inst_ret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.A3_WB     = a3_p1;
  assign bus.WE_WB     = we_p1;
  assign bus.WD_WB     = wd_p1;
  assign bus.Valid_W   = vld_p1;
  assign bus.LoadErr_W = err_p1;
  assign bus.InstRet   = inst_ret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for the capture path, then
// hand sequences for stall, flush, counter wrap and asynchronous reset.
module tb_mem_wb_stage;
  localparam int CW = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;

  mem_wb_stage_if #(.CNT_W(CW)) bus ();

  mem_wb_stage #(.CNT_W(CW)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  a3;
    logic [1:0]  ws;
    logic [2:0]  lt;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] pc8;
    logic [4:0]  ea3;
    logic        ewe;
    logic [31:0] ewd;
    logic        evld;
    logic        eerr;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [4:0] a3, input logic we,
                         input logic [31:0] wd, input logic vld, input logic err,
                         input int cnt);
    chk({nm, ".a3"},  32'(bus.A3_WB),     32'(a3));
    chk({nm, ".we"},  32'(bus.WE_WB),     32'(we));
    chk({nm, ".wd"},  bus.WD_WB,          wd);
    chk({nm, ".vld"}, 32'(bus.Valid_W),   32'(vld));
    chk({nm, ".err"}, 32'(bus.LoadErr_W), 32'(err));
    chk({nm, ".cnt"}, 32'(bus.InstRet),   32'(cnt));
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] a3,
                       input logic [1:0] ws, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] pc8);
    bus.Valid_M    = v;
    bus.RegWrite_M = rw;
    bus.A3_M       = a3;
    bus.WbSel_M    = ws;
    bus.LoadType_M = lt;
    bus.ALUOut_M   = alu;
    bus.MemRD_M    = rd;
    bus.PC8_M      = pc8;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //         v  rw a3     ws    lt    alu           rd            pc8           ea3    ewe   ewd           evld  eerr
    vt[0]  = '{1, 1, 5'd8,  2'd0, 3'd0, 32'h12345678, 32'h80FF7F01, 32'h0,        5'd8,  1'b1, 32'h12345678, 1'b1, 1'b0};
    vt[1]  = '{1, 1, 5'd2,  2'd1, 3'd1, 32'h00000100, 32'h80FF7F01, 32'h0,        5'd2,  1'b1, 32'hFFFFFF80, 1'b1, 1'b0};
    vt[2]  = '{1, 1, 5'd3,  2'd1, 3'd2, 32'h00000101, 32'h80FF7F01, 32'h0,        5'd3,  1'b1, 32'h000000FF, 1'b1, 1'b0};
    vt[3]  = '{1, 1, 5'd3,  2'd1, 3'd3, 32'h00000102, 32'h80FF7F01, 32'h0,        5'd3,  1'b1, 32'h00007F01, 1'b1, 1'b0};
    vt[4]  = '{1, 1, 5'd3,  2'd1, 3'd4, 32'h00000100, 32'h80FF7F01, 32'h0,        5'd3,  1'b1, 32'h000080FF, 1'b1, 1'b0};
    vt[5]  = '{1, 1, 5'd9,  2'd1, 3'd0, 32'h00000102, 32'h80FF7F01, 32'h0,        5'd9,  1'b0, 32'h80FF7F01, 1'b1, 1'b1};
    vt[6]  = '{1, 1, 5'd9,  2'd1, 3'd3, 32'h00000101, 32'h80FF7F01, 32'h0,        5'd9,  1'b0, 32'hFFFF80FF, 1'b1, 1'b1};
    vt[7]  = '{1, 1, 5'd9,  2'd1, 3'd0, 32'h00000104, 32'h80FF7F01, 32'h0,        5'd9,  1'b1, 32'h80FF7F01, 1'b1, 1'b0};
    vt[8]  = '{1, 1, 5'd31, 2'd2, 3'd0, 32'h00000040, 32'h80FF7F01, 32'h00003008, 5'd31, 1'b1, 32'h00003008, 1'b1, 1'b0};
    vt[9]  = '{1, 1, 5'd0,  2'd0, 3'd0, 32'h00000055, 32'h80FF7F01, 32'h0,        5'd0,  1'b0, 32'h00000055, 1'b1, 1'b0};
    vt[10] = '{0, 1, 5'd5,  2'd1, 3'd0, 32'h00000102, 32'h80FF7F01, 32'h0,        5'd0,  1'b0, 32'h80FF7F01, 1'b0, 1'b0};
    vt[11] = '{1, 1, 5'd4,  2'd1, 3'd1, 32'h00000103, 32'h80FF7F01, 32'h0,        5'd4,  1'b1, 32'h00000001, 1'b1, 1'b0};
    vt[12] = '{1, 1, 5'd4,  2'd1, 3'd5, 32'h00000108, 32'h80FF7F01, 32'h0,        5'd4,  1'b1, 32'h80FF7F01, 1'b1, 1'b0};
    vt[13] = '{1, 0, 5'd7,  2'd3, 3'd0, 32'hDEADBEE0, 32'h80FF7F01, 32'h11111111, 5'd7,  1'b0, 32'hDEADBEE0, 1'b1, 1'b0};
    vt[14] = '{1, 1, 5'd6,  2'd0, 3'd0, 32'h00000003, 32'h80FF7F01, 32'h0,        5'd6,  1'b1, 32'h00000003, 1'b1, 1'b0};

    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    drive(1'b1, 1'b1, 5'd1, 2'd0, 3'd0, 32'hFFFFFFFF, 32'h0, 32'h0);

    // Reset holds everything at zero even across edges with valid input.
    #12;
    chk_all("reset", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    Reset_n = 1'b1;

    // Capture path from the vector table.
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].v, vt[i].rw, vt[i].a3, vt[i].ws, vt[i].lt, vt[i].alu, vt[i].rd, vt[i].pc8);
      tick();
      if (vt[i].v) exp_cnt = (exp_cnt + 1) % 16;
      chk_all($sformatf("vec%0d", i), vt[i].ea3, vt[i].ewe, vt[i].ewd, vt[i].evld, vt[i].eerr, exp_cnt);
    end

    // Stall for three cycles: vec14 results and the count stay frozen.
    drive(1'b1, 1'b1, 5'd10, 2'd0, 3'd0, 32'h0000AAAA, 32'h0, 32'h0);
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("stall%0d", i), 5'd6, 1'b1, 32'h00000003, 1'b1, 1'b0, 14);
    end

    // Stall released: capture brings the count to all-ones.
    bus.Stall = 1'b0;
    tick();
    chk_all("unstall", 5'd10, 1'b1, 32'h0000AAAA, 1'b1, 1'b0, 15);

    // Stall and Flush together: flush wins.
    bus.Stall = 1'b1;
    bus.Flush = 1'b1;
    tick();
    chk_all("stallflush", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 15);

    // One more valid capture wraps the counter to zero.
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    drive(1'b1, 1'b1, 5'd12, 2'd0, 3'd0, 32'h00000C0C, 32'h0, 32'h0);
    tick();
    chk_all("wrap", 5'd12, 1'b1, 32'h00000C0C, 1'b1, 1'b0, 0);

    // Flush alone with a valid misaligned load presented.
    bus.Flush = 1'b1;
    drive(1'b1, 1'b1, 5'd13, 2'd1, 3'd0, 32'h00000001, 32'h12345678, 32'h0);
    tick();
    chk_all("flush", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 0);

    // Pending write cleared immediately by an asynchronous reset pulse.
    bus.Flush = 1'b0;
    drive(1'b1, 1'b1, 5'd14, 2'd0, 3'd0, 32'h0000BEEF, 32'h0, 32'h0);
    tick();
    chk_all("prereset", 5'd14, 1'b1, 32'h0000BEEF, 1'b1, 1'b0, 1);
    Reset_n = 1'b0;
    #1;
    chk_all("asyncrst", 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    #2;
    Reset_n = 1'b1;
    drive(1'b0, 1'b1, 5'd14, 2'd0, 3'd0, 32'h0000BEEF, 32'h0, 32'h0);
    tick();
    chk_all("postrst_bubble", 5'd0, 1'b0, 32'h0000BEEF, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b1, 5'd15, 2'd2, 3'd0, 32'h0, 32'h0, 32'h00004010);
    tick();
    chk_all("postrst_cap", 5'd15, 1'b1, 32'h00004010, 1'b1, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
